block_lock_fsm: RTL
===================

BLOCK_LOCK_FSM -- requirements
Module: block_lock_fsm

Interface
REQ-001 SHALL have parameter LEN_CODED_BLOCK, default 66: coded block length in bits; the index range is 0..LEN_CODED_BLOCK-1.
REQ-002 SHALL have parameter UNLOCK_WIN, default 64: consecutive valid sync headers required to acquire lock.
REQ-003 SHALL have parameter LOCK_WIN, default 1024: monitoring window length, in blocks, while locked.
REQ-004 SHALL have parameter INV_MAX, default 65: invalid headers within one LOCK_WIN that cause loss of lock.
REQ-005 SHALL have parameter SLIP_WAIT, default 2: valid blocks discarded after each slip while the aligner settles.
REQ-006 SHALL have port i_clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port i_reset, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port i_enable, input, 1 bit: lock search enable; low forces LOCK_INIT.
REQ-009 SHALL have port i_valid, input, 1 bit: a new aligned 66-bit block is present this cycle.
REQ-010 SHALL have port i_sh, input, 2 bits: sync header of the aligned block, valid only with i_valid.
REQ-011 SHALL have port o_index, output, $clog2(LEN_CODED_BLOCK) bits: bit offset driving the block aligner.
REQ-012 SHALL have port o_block_lock, output, 1 bit: block lock achieved.
REQ-013 SHALL have port o_slip, output, 1 bit: one-cycle pulse whenever o_index advances.

Function
REQ-014 SHALL classify a sync header as valid iff i_sh is 2'b01 or 2'b10; 2'b00 and 2'b11 SHALL count as invalid.
REQ-015 SHALL implement states LOCK_INIT, TEST_SH, SLIP and SLIP_WAIT.
REQ-016 LOCK_INIT SHALL clear both counters and o_block_lock, then go to TEST_SH on the next cycle when i_enable=1.
REQ-017 In TEST_SH, each i_valid SHALL increment sh_cnt; an invalid header SHALL also increment inv_cnt.
REQ-018 When unlocked, any invalid header SHALL cause a transition to SLIP.
REQ-019 When unlocked, the UNLOCK_WIN-th consecutive valid header SHALL set o_block_lock and clear the counters.
REQ-020 When locked, inv_cnt reaching INV_MAX (current block included) SHALL clear o_block_lock and cause a transition to SLIP.
REQ-021 When locked, sh_cnt reaching LOCK_WIN with inv_cnt<INV_MAX SHALL clear both counters and keep lock.
REQ-022 If the INV_MAX threshold and the LOCK_WIN end occur on the same block, loss of lock SHALL take priority.
REQ-023 SLIP SHALL last exactly one cycle, assert o_slip, and set o_index to o_index+1, wrapping LEN_CODED_BLOCK-1 to 0.
REQ-024 SLIP SHALL clear both counters and go to SLIP_WAIT.
REQ-025 SLIP_WAIT SHALL ignore the headers of SLIP_WAIT valid blocks and then return to TEST_SH.
REQ-026 If SLIP_WAIT=0, SLIP SHALL go directly to TEST_SH.
REQ-027 All outputs SHALL be registered: o_block_lock and o_slip/o_index change in the cycle after the deciding i_valid.
REQ-028 Cycles with i_valid=0 SHALL change no counter or state, except the LOCK_INIT->TEST_SH and SLIP exits.
REQ-029 i_enable=0 in any state SHALL force LOCK_INIT next cycle, clear o_block_lock, and hold o_index.
REQ-030 Counters SHALL be sized $clog2(LOCK_WIN+1) and $clog2(INV_MAX+1) and SHALL never wrap.

Reset
REQ-031 i_reset=0 SHALL immediately force state LOCK_INIT, o_index=0, o_block_lock=0, o_slip=0 and counters=0.
REQ-032 Reset asserted mid-slip or mid-window SHALL discard all progress; deassertion SHALL be synchronized to i_clock.

Structure
REQ-033 Package pcs_sync_pkg SHALL hold LEN_CODED_BLOCK, the state encoding, and the SH_DATA=2'b01 / SH_CTRL=2'b10 constants.
REQ-034 The window counter pair (sh_cnt, inv_cnt with clear/threshold flags) SHALL be one sub-module, sh_window_counter.

Verification
REQ-035 Reset, enable, then 64 blocks with i_sh=01 SHALL give o_block_lock=1 the cycle after block 64, with o_index=0 and no o_slip.
REQ-036 Unlocked, with the header valid only at offset 5, SHALL give exactly 5 o_slip pulses, o_index=5, then lock after 64 further valid headers.
REQ-037 Locked, with 64 invalid headers in 1024 blocks SHALL keep lock; 65 invalid headers SHALL drop lock and pulse o_slip.
REQ-038 Starting at o_index=65, a slip SHALL wrap o_index to 0; the next SLIP_WAIT=2 invalid blocks SHALL cause no further slip.
REQ-039 Asserting i_reset mid-SLIP_WAIT and asserting i_enable=0 while locked SHALL both give o_block_lock=0 next cycle; reset SHALL also give o_index=0.

Source files
------------

// File: rtl/pcs_sync_pkg.sv
// Shared constants and state encoding for 64b/66b block synchronisation.
package pcs_sync_pkg;

  localparam int LEN_CODED_BLOCK = 66;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  typedef enum logic [1:0] {
    ST_LOCK_INIT = 2'd0,
    ST_TEST_SH   = 2'd1,
    ST_SLIP      = 2'd2,
    ST_SLIP_WAIT = 2'd3
  } lock_state_t;

  function automatic logic sh_is_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/sh_window_counter.sv
// Saturating sync-header / invalid-header counter pair with last-block flags.
module sh_window_counter #(
  parameter int LOCK_WIN = 1024,
  parameter int INV_MAX  = 65,
  parameter int SH_W     = $clog2(LOCK_WIN + 1),
  parameter int INV_W    = $clog2(INV_MAX + 1)
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_clear,
  input  logic            i_count,
  input  logic            i_invalid,
  output logic [SH_W-1:0] o_sh_cnt,
  output logic            o_win_last,
  output logic            o_inv_last
);

  logic [INV_W-1:0] inv_cnt;

  // Clear wins over count so a deciding block never leaves residue behind.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_sh_cnt <= '0;
      inv_cnt  <= '0;
    end else if (i_clear) begin
      o_sh_cnt <= '0;
      inv_cnt  <= '0;
    end else if (i_count) begin
      if (o_sh_cnt != SH_W'(LOCK_WIN))
        o_sh_cnt <= o_sh_cnt + SH_W'(1);
      if (i_invalid && (inv_cnt != INV_W'(INV_MAX)))
        inv_cnt <= inv_cnt + INV_W'(1);
    end
  end

  // True when the block being counted right now completes the window / hits the limit.
  assign o_win_last = (o_sh_cnt == SH_W'(LOCK_WIN - 1));
  assign o_inv_last = (inv_cnt == INV_W'(INV_MAX - 1));

endmodule

// File: rtl/block_lock_fsm.sv
// 64b/66b block lock state machine: hunts the sync-header offset and tracks lock.
module block_lock_fsm #(
  parameter int LEN_CODED_BLOCK = pcs_sync_pkg::LEN_CODED_BLOCK,
  parameter int UNLOCK_WIN      = 64,
  parameter int LOCK_WIN        = 1024,
  parameter int INV_MAX         = 65,
  parameter int SLIP_WAIT       = 2
) (
  input  logic                               i_clock,
  input  logic                               i_reset,
  input  logic                               i_enable,
  input  logic                               i_valid,
  input  logic [1:0]                         i_sh,
  output logic [$clog2(LEN_CODED_BLOCK)-1:0] o_index,
  output logic                               o_block_lock,
  output logic                               o_slip,
  output pcs_sync_pkg::lock_state_t          o_state
);
  import pcs_sync_pkg::*;

  localparam int IDX_W  = $clog2(LEN_CODED_BLOCK);
  localparam int SH_W   = $clog2(LOCK_WIN + 1);
  localparam int WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((SLIP_WAIT > 0) ? SLIP_WAIT - 1 : 0);

  // i_valid is a one-way qualifier: a block is consumed on every rising edge where
  // i_valid=1; there is no backpressure, and i_sh is ignored while i_valid=0.

  logic [1:0]        rst_sync;
  logic              rst_n;
  lock_state_t       state_q, state_d;
  logic [IDX_W-1:0]  index_d;
  logic              lock_d, slip_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              cnt_clear, cnt_en;
  logic [SH_W-1:0]   sh_cnt;
  logic              win_last, inv_last, sh_ok;

  // Assert asynchronously, release on the clock.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  sh_window_counter #(
    .LOCK_WIN (LOCK_WIN),
    .INV_MAX  (INV_MAX)
  ) u_win (
    .i_clock    (i_clock),
    .i_reset    (rst_n),
    .i_clear    (cnt_clear),
    .i_count    (cnt_en),
    .i_invalid  (!sh_ok),
    .o_sh_cnt   (sh_cnt),
    .o_win_last (win_last),
    .o_inv_last (inv_last)
  );

  assign sh_ok = sh_is_valid(i_sh);

  always_ff @(posedge i_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOCK_INIT;
      o_index      <= '0;
      o_block_lock <= 1'b0;
      o_slip       <= 1'b0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      o_index      <= index_d;
      o_block_lock <= lock_d;
      o_slip       <= slip_d;
      wait_q       <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    index_d   = o_index;
    lock_d    = o_block_lock;
    slip_d    = 1'b0;
    wait_d    = wait_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    if (!i_enable) begin
      state_d   = ST_LOCK_INIT;
      lock_d    = 1'b0;
      cnt_clear = 1'b1;
    end else begin
      case (state_q)
        ST_LOCK_INIT: begin
          cnt_clear = 1'b1;
          lock_d    = 1'b0;
          state_d   = ST_TEST_SH;
        end
        ST_TEST_SH: begin
          if (i_valid) begin
            cnt_en = 1'b1;
            // Unlocked: one bad header slips. Locked: only the INV_MAX-th in a window does.
            if ((!o_block_lock && !sh_ok) || (o_block_lock && !sh_ok && inv_last)) begin
              state_d   = ST_SLIP;
              lock_d    = 1'b0;
              slip_d    = 1'b1;
              cnt_clear = 1'b1;
              index_d   = (o_index == IDX_W'(LEN_CODED_BLOCK - 1)) ? '0 : o_index + IDX_W'(1);
            end else if (!o_block_lock && (sh_cnt == SH_W'(UNLOCK_WIN - 1))) begin
              lock_d    = 1'b1;
              cnt_clear = 1'b1;
            end else if (o_block_lock && win_last) begin
              cnt_clear = 1'b1;
            end
          end
        end
        ST_SLIP: begin
          cnt_clear = 1'b1;
          wait_d    = '0;
          state_d   = (SLIP_WAIT == 0) ? ST_TEST_SH : ST_SLIP_WAIT;
        end
        ST_SLIP_WAIT: begin
          if (i_valid) begin
            if (wait_q == WAIT_LAST) state_d = ST_TEST_SH;
            else                     wait_d  = wait_q + WAIT_W'(1);
          end
        end
        default: state_d = ST_LOCK_INIT;
      endcase
    end
  end

  assign o_state = state_q;

endmodule
